sseg_scroll_ctrl: RTL and testbench

SSEG_SCROLL_CTRL -- requirements
Module: sseg_scroll_ctrl

---
 rtl/sseg_scroll_ctrl.sv | 136 +++++++++++++
 tb/tb_sseg_scroll_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scroll_ctrl
//  Purpose  : Eight-digit seven-segment scrolling message controller. Holds a
//             16-entry message of digit codes and shifts it right-to-left
//             across slots d0..d7, one step per TICK_FINAL+1 clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scroll_ctrl #(
  parameter int TICK_FINAL = 49_999_999,
  parameter int DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [5:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       busy,
  output logic       done,
  output logic [5:0] d7,
  output logic [5:0] d6,
  output logic [5:0] d5,
  output logic [5:0] d4,
  output logic [5:0] d3,
  output logic [5:0] d2,
  output logic [5:0] d1,
  output logic [5:0] d0
);

  localparam int TW = (TICK_FINAL > 0) ? $clog2(TICK_FINAL + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_FINAL);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SCROLL = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [4:0]    count;          // number of stored characters, 0..16
  logic [4:0]    ptr;            // step index within the current pass, 0..count+7
  logic [TW-1:0] tick;
  logic [5:0]    msg_mem [DEPTH];
  logic [5:0]    digit   [8];

  logic is_idle;
  logic wr_fire;
  logic start_fire;
  logic step;
  logic pass_end;

  // Handshake and event decode shared by the FSM and the datapath
  always_comb begin
    is_idle    = (state == S_IDLE);
    wr_ready   = is_idle && (count < 5'(DEPTH));
    // clear takes priority over a write and also suppresses start
    wr_fire    = wr_valid && wr_ready && !clear;
    start_fire = is_idle && start && !clear && (count != 5'd0);
    // stop overrides a step landing in the same cycle
    step       = !is_idle && !stop && (tick == TICK_LAST);
    // the final step of a pass pushes the last blank in; display is then empty
    pass_end   = step && (ptr == count + 5'd7);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_fire) state_nxt = S_SCROLL;
      S_SCROLL: if (stop || (pass_end && !loop)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the state
  always_comb begin
    busy = (state == S_SCROLL);
  end

  // Message storage; contents survive stop and clear, only count is reset
  always_ff @(posedge clk) begin
    if (wr_fire) msg_mem[count[3:0]] <= wr_data;
  end

  // Character count maintenance (only changes while idle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                count <= 5'd0;
    else if (is_idle && clear)   count <= 5'd0;
    else if (wr_fire)            count <= count + 5'd1;
  end

  // Scroll datapath: tick divider, pass pointer and display shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr  <= 5'd0;
      tick <= '0;
      for (int i = 0; i < 8; i++) digit[i] <= 6'd0;
    end else if (start_fire || (!is_idle && stop)) begin
      ptr  <= 5'd0;
      tick <= '0;
      for (int i = 0; i < 8; i++) digit[i] <= 6'd0;
    end else if (!is_idle) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
      if (step) begin
        for (int i = 7; i > 0; i--) digit[i] <= digit[i-1];
        digit[0] <= (ptr < count) ? msg_mem[ptr[3:0]] : 6'd0;
        ptr      <= pass_end ? 5'd0 : ptr + 5'd1;
      end
    end
  end

  // One-cycle completion pulse, lands on the first idle cycle after a pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= pass_end && !loop;
  end

  assign d7 = digit[7];
  assign d6 = digit[6];
  assign d5 = digit[5];
  assign d4 = digit[4];
  assign d3 = digit[3];
  assign d2 = digit[2];
  assign d1 = digit[1];
  assign d0 = digit[0];

endmodule
`default_nettype wire

// File: tb/tb_sseg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scroll_ctrl
//  Purpose  : Self-checking bench for sseg_scroll_ctrl (TICK_FINAL = 3).
//             Reference model tracks the message and the step number within
//             a pass; slot i after s steps shows character s-i (1-based).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scroll_ctrl;

  localparam int TF = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid;
  logic [5:0] wr_data;
  logic       wr_ready;
  logic       clear, start, stop, loop;
  logic       busy, done;
  logic [5:0] d7, d6, d5, d4, d3, d2, d1, d0;

  int checks = 0;
  int errors = 0;

  sseg_scroll_ctrl #(.TICK_FINAL(TF), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear(clear), .start(start), .stop(stop), .loop(loop),
    .busy(busy), .done(done),
    .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_scroll;
  int         m_s;       // steps taken in the current pass
  int         m_phase;   // clocks since the last step
  int         m_cnt;
  logic [5:0] m_msg [16];
  bit         m_done;

  function automatic logic [5:0] get_d(int i);
    case (i)
      0: return d0; 1: return d1; 2: return d2; 3: return d3;
      4: return d4; 5: return d5; 6: return d6; default: return d7;
    endcase
  endfunction

  function automatic logic [5:0] exp_digit(int i);
    int k = m_s - i;
    if (m_scroll && k >= 1 && k <= m_cnt) return m_msg[k-1];
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_scroll = 0; m_s = 0; m_phase = 0; m_cnt = 0; m_done = 0;
  endtask

  // Applies the effect of one rising edge given the inputs now being driven
  task automatic model_update();
    int old;
    if (!reset_n) begin
      model_reset();
    end else if (!m_scroll) begin
      m_done = 0;
      old = m_cnt;
      if (clear) m_cnt = 0;
      else begin
        if (wr_valid && m_cnt < 16) begin
          m_msg[m_cnt] = wr_data;
          m_cnt++;
        end
        if (start && old > 0) begin
          m_scroll = 1; m_s = 0; m_phase = 0;
        end
      end
    end else begin
      m_done = 0;
      if (stop) m_scroll = 0;
      else if (m_phase == TF) begin
        m_phase = 0;
        m_s++;
        if (m_s == m_cnt + 8) begin
          if (loop) m_s = 0;
          else begin m_scroll = 0; m_done = 1; end
        end
      end else m_phase++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy", {31'd0, busy}, {31'd0, m_scroll});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, (!m_scroll && m_cnt < 16)});
    chk("done", {31'd0, done}, {31'd0, m_done});
    for (int i = 0; i < 8; i++)
      chk($sformatf("d%0d", i), {26'd0, get_d(i)}, {26'd0, exp_digit(i)});
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked at negedge
  task automatic cyc();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_data = 6'd0; clear = 0; start = 0; stop = 0; loop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    cyc();
    cyc();
    reset_n = 1;
    cyc();
  endtask

  task automatic write_code(input logic [5:0] c);
    idle_inputs(); wr_valid = 1; wr_data = c; cyc(); idle_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic bit all_blank();
    return ({d7, d6, d5, d4, d3, d2, d1, d0} == 48'd0);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         wv;
    logic [5:0] wd;
    bit         clr, st, sp, lp;
    bit         e_busy, e_ready, e_done;
    logic [5:0] e_d0;
  } vec_t;

  vec_t vt [17];
  int   done_seen;

  initial begin
    reset_n = 1;
    idle_inputs();
    @(negedge clk);

    //          wv wd     clr st sp lp   busy rdy done d0
    vt[0]  = '{0, 6'h00, 0, 0, 0, 0,   0, 1, 0, 6'h00}; // reset state
    vt[1]  = '{0, 6'h00, 0, 1, 0, 0,   0, 1, 0, 6'h00}; // start, empty
    vt[2]  = '{1, 6'h23, 1, 0, 0, 0,   0, 1, 0, 6'h00}; // clear beats write
    vt[3]  = '{0, 6'h00, 0, 1, 0, 0,   0, 1, 0, 6'h00}; // still empty
    vt[4]  = '{1, 6'h23, 0, 0, 0, 0,   0, 1, 0, 6'h00};
    vt[5]  = '{0, 6'h00, 1, 0, 0, 0,   0, 1, 0, 6'h00}; // clear
    vt[6]  = '{0, 6'h00, 0, 1, 0, 0,   0, 1, 0, 6'h00}; // empty again
    vt[7]  = '{1, 6'h25, 0, 1, 0, 0,   0, 1, 0, 6'h00}; // pre-write count 0
    vt[8]  = '{0, 6'h00, 0, 1, 0, 0,   1, 0, 0, 6'h00}; // starts
    vt[9]  = '{0, 6'h00, 0, 0, 1, 0,   0, 1, 0, 6'h00}; // stop
    vt[10] = '{1, 6'h2A, 0, 0, 0, 0,   0, 1, 0, 6'h00};
    vt[11] = '{0, 6'h00, 0, 1, 0, 0,   1, 0, 0, 6'h00};
    vt[12] = '{0, 6'h00, 0, 0, 0, 0,   1, 0, 0, 6'h00};
    vt[13] = '{0, 6'h00, 0, 0, 0, 0,   1, 0, 0, 6'h00};
    vt[14] = '{0, 6'h00, 0, 0, 0, 0,   1, 0, 0, 6'h00};
    vt[15] = '{0, 6'h00, 0, 0, 0, 0,   1, 0, 0, 6'h25}; // first step: buf[0]
    vt[16] = '{0, 6'h00, 0, 0, 1, 0,   0, 1, 0, 6'h00}; // stop blanks

    do_reset();
    for (int r = 0; r < 17; r++) begin
      wr_valid = vt[r].wv; wr_data = vt[r].wd; clear = vt[r].clr;
      start = vt[r].st; stop = vt[r].sp; loop = vt[r].lp;
      cyc();
      chk($sformatf("vec%0d_busy", r), {31'd0, busy}, {31'd0, vt[r].e_busy});
      chk($sformatf("vec%0d_ready", r), {31'd0, wr_ready}, {31'd0, vt[r].e_ready});
      chk($sformatf("vec%0d_done", r), {31'd0, done}, {31'd0, vt[r].e_done});
      chk($sformatf("vec%0d_d0", r), {26'd0, d0}, {26'd0, vt[r].e_d0});
    end
    idle_inputs();

    // Two-character pass, no loop: 10 steps, then done once
    do_reset();
    write_code(6'h23);
    write_code(6'h25);
    start = 1; cyc(); idle_inputs();
    run(4);
    chk("two_step1_d0", {26'd0, d0}, 32'h23);
    run(4);
    chk("two_step2_d1", {26'd0, d1}, 32'h23);
    chk("two_step2_d0", {26'd0, d0}, 32'h25);
    run(32);
    chk("two_end_done", {31'd0, done}, 32'd1);
    chk("two_end_busy", {31'd0, busy}, 32'd0);
    chk("two_end_blank", {31'd0, all_blank()}, 32'd1);
    cyc();
    chk("two_done_pulse_len", {31'd0, done}, 32'd0);

    // Seventeen back-to-back writes: sixteen land, then a full pass
    do_reset();
    wr_valid = 1;
    for (int i = 0; i < 17; i++) begin
      wr_data = (i == 16) ? 6'h3F : {1'b1, i[3:0], 1'b0};
      cyc();
      if (i == 15) chk("full_ready_low", {31'd0, wr_ready}, 32'd0);
    end
    idle_inputs();
    start = 1; cyc(); idle_inputs();
    run(16 * 4);
    chk("full_step16_d0", {26'd0, d0}, 32'h3E);
    chk("full_step16_d7", {26'd0, d7}, 32'h30);
    run(8 * 4);
    chk("full_end_done", {31'd0, done}, 32'd1);

    // Looping single-character message
    do_reset();
    write_code(6'h3F);
    loop = 1; start = 1; cyc(); start = 0;
    done_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (done) done_seen++;
      if (i == 4)  chk("loop_step1_d0", {26'd0, d0}, 32'h3F);
      if (i == 36) chk("loop_step9_blank", {31'd0, all_blank()}, 32'd1);
      if (i == 40) chk("loop_step10_d0", {26'd0, d0}, 32'h3F);
    end
    chk("loop_no_done", done_seen, 0);
    chk("loop_busy", {31'd0, busy}, 32'd1);
    loop = 0; stop = 1; cyc(); idle_inputs();

    // stop coincident with step 3, then replay from buf[0]
    do_reset();
    write_code(6'h11); write_code(6'h13); write_code(6'h15);
    start = 1; cyc(); idle_inputs();
    run(11);
    chk("stop_pre_d0", {26'd0, d0}, 32'h13);
    stop = 1; cyc(); idle_inputs();
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_blank", {31'd0, all_blank()}, 32'd1);
    chk("stop_done", {31'd0, done}, 32'd0);
    start = 1; cyc(); idle_inputs();
    run(4);
    chk("replay_d0", {26'd0, d0}, 32'h11);

    // Asynchronous reset mid-scroll
    run(6);
    #2 reset_n = 0;
    #1;
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_blank", {31'd0, all_blank()}, 32'd1);
    chk("areset_ready", {31'd0, wr_ready}, 32'd1);
    chk("areset_done", {31'd0, done}, 32'd0);
    model_reset();
    @(negedge clk);
    cyc();
    reset_n = 1;
    start = 1; cyc(); idle_inputs();
    chk("areset_count0", {31'd0, busy}, 32'd0);

    // Randomised traffic against the model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 900; i++) begin
        wr_valid = ($urandom_range(0, 99) < 40);
        wr_data  = 6'($urandom);
        clear    = ($urandom_range(0, 99) < 3);
        start    = ($urandom_range(0, 99) < 8);
        stop     = ($urandom_range(0, 199) < 1);
        loop     = ($urandom_range(0, 1) == 1);
        cyc();
      end
      idle_inputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
